pixel_cvt: RTL and testbench

Parametrised colour-space converter for the video pipeline, placed between the camera/RGB source and downstream detection logic. It converts RGB to one of four modes: bypass, Y-only gray, full YCbCr (BT.601, 8-bit fixed-point coefficients), or binary threshold. Mode and threshold are software-selectable and are applied only at frame boundaries. Timing strobes (de/hs/vs) are delay-matched to the pixel data with a fixed 3-cycle latency in every mode.

---
 rtl/pixel_cvt.sv | 148 ++++++++++++++
 tb/tb_pixel_cvt.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_cvt.sv
// RGB colour-space converter: bypass, gray (Y), YCbCr (BT.601) or binary threshold.
// Three-stage free-running pipeline; mode/threshold tags travel with each pixel.
module pixel_cvt #(
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3*DW-1:0] din,
  input  logic            de_in,
  input  logic            hs_in,
  input  logic            vs_in,
  input  logic [1:0]      mode,
  input  logic [DW-1:0]   thresh,
  output logic [3*DW-1:0] dout,
  output logic            de_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic [1:0]      mode_act
);

  localparam int unsigned PW     = DW + 9;
  localparam int unsigned SW     = DW + 11;
  localparam int          Coef [9] = '{77, 150, 29, -43, -85, 128, 128, -107, -21};
  localparam int          Offset = 1 << (DW - 1);
  localparam int          MaxInt = (1 << DW) - 1;

  logic            r_vs_d;
  logic [1:0]      r_mode_act;
  logic [DW-1:0]   r_thr_act;

  // Mode and threshold only change on a vsync rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d     <= 1'b0;
      r_mode_act <= 2'd1;
      r_thr_act  <= '0;
    end else begin
      r_vs_d <= vs_in;
      if (vs_in && !r_vs_d) begin
        r_mode_act <= mode;
        r_thr_act  <= thresh;
      end
    end
  end

  assign mode_act = r_mode_act;

  // Stage 1: capture pixel, strobes and the tags in force when the pixel entered
  logic [3*DW-1:0] r_s1_pix;
  logic            r_s1_de, r_s1_hs, r_s1_vs;
  logic [1:0]      r_s1_mode;
  logic [DW-1:0]   r_s1_thr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_pix  <= '0;
      r_s1_de   <= 1'b0;
      r_s1_hs   <= 1'b0;
      r_s1_vs   <= 1'b0;
      r_s1_mode <= '0;
      r_s1_thr  <= '0;
    end else begin
      r_s1_pix  <= din;
      r_s1_de   <= de_in;
      r_s1_hs   <= hs_in;
      r_s1_vs   <= vs_in;
      r_s1_mode <= r_mode_act;
      r_s1_thr  <= r_thr_act;
    end
  end

  logic signed [PW-1:0] w_chan [3];

  for (genvar c = 0; c < 3; c++) begin : g_chan
    assign w_chan[c] = $signed({{(PW - DW){1'b0}}, r_s1_pix[(3-c)*DW-1 -: DW]});
  end

  // Stage 2: nine coefficient products, rows ordered Y, Cb, Cr
  logic signed [PW-1:0] r_s2_prod [9];
  logic [3*DW-1:0]      r_s2_pix;
  logic                 r_s2_de, r_s2_hs, r_s2_vs;
  logic [1:0]           r_s2_mode;
  logic [DW-1:0]        r_s2_thr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) r_s2_prod[i] <= '0;
      r_s2_pix  <= '0;
      r_s2_de   <= 1'b0;
      r_s2_hs   <= 1'b0;
      r_s2_vs   <= 1'b0;
      r_s2_mode <= '0;
      r_s2_thr  <= '0;
    end else begin
      for (int i = 0; i < 9; i++) r_s2_prod[i] <= w_chan[i % 3] * PW'(Coef[i]);
      r_s2_pix  <= r_s1_pix;
      r_s2_de   <= r_s1_de;
      r_s2_hs   <= r_s1_hs;
      r_s2_vs   <= r_s1_vs;
      r_s2_mode <= r_s1_mode;
      r_s2_thr  <= r_s1_thr;
    end
  end

  // Stage 3: round, scale, offset chroma, clamp, then select per mode tag
  logic signed [SW-1:0] w_sum [3];
  logic [DW-1:0]        w_ch  [3];
  logic [3*DW-1:0]      w_pix;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_sum[k] = ((SW'(r_s2_prod[3*k]) + SW'(r_s2_prod[3*k+1]) + SW'(r_s2_prod[3*k+2])
                  + SW'(128)) >>> 8) + ((k == 0) ? SW'(0) : SW'(Offset));
      if (w_sum[k] < 0) begin
        w_ch[k] = '0;
      end else if (w_sum[k] > SW'(MaxInt)) begin
        w_ch[k] = '1;
      end else begin
        w_ch[k] = w_sum[k][DW-1:0];
      end
    end

    w_pix = '0;
    if (r_s2_de) begin
      case (r_s2_mode)
        2'd0:    w_pix = r_s2_pix;
        2'd1:    w_pix = {w_ch[0], {(2*DW){1'b0}}};
        2'd2:    w_pix = {w_ch[0], w_ch[1], w_ch[2]};
        default: w_pix = (w_ch[0] >= r_s2_thr) ? '1 : '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      de_out <= 1'b0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
    end else begin
      dout   <= w_pix;
      de_out <= r_s2_de;
      hs_out <= r_s2_hs;
      vs_out <= r_s2_vs;
    end
  end

endmodule

// File: tb/tb_pixel_cvt.sv
// Bench for pixel_cvt: directed spec cases plus randomized frames, all checked
// against an arithmetic reference model with a queue standing in for pipeline delay.
module tb_pixel_cvt;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 3 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  din;
  logic          de_in, hs_in, vs_in;
  logic [1:0]    mode;
  logic [DW-1:0] thresh;
  logic [W-1:0]  dout;
  logic          de_out, hs_out, vs_out;
  logic [1:0]    mode_act;

  always #5 clk = ~clk;

  pixel_cvt #(.DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .de_in    (de_in),
    .hs_in    (hs_in),
    .vs_in    (vs_in),
    .mode     (mode),
    .thresh   (thresh),
    .dout     (dout),
    .de_out   (de_out),
    .hs_out   (hs_out),
    .vs_out   (vs_out),
    .mode_act (mode_act)
  );

  typedef struct {
    logic [W-1:0] px;
    logic         de;
    logic         hs;
    logic         vs;
  } out_t;

  out_t          exp_q [$];
  logic [1:0]    m_mode;
  logic [DW-1:0] m_thr;
  logic          m_vs_prev;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] clamp(input int v);
    if (v < 0) return '0;
    if (v > (1 << DW) - 1) return '1;
    return DW'(v);
  endfunction

  // Expected output pixel from the conversion rules, in plain integer arithmetic.
  function automatic logic [W-1:0] ref_pix(input logic [W-1:0] p, input logic de,
                                           input logic [1:0] md, input logic [DW-1:0] th);
    int r, g, b;
    logic [DW-1:0] y, cb, cr;
    r  = int'(p[W-1 -: DW]);
    g  = int'(p[2*DW-1 -: DW]);
    b  = int'(p[DW-1:0]);
    y  = clamp((77 * r + 150 * g + 29 * b + 128) >>> 8);
    cb = clamp(((-43 * r - 85 * g + 128 * b + 128) >>> 8) + (1 << (DW - 1)));
    cr = clamp(((128 * r - 107 * g - 21 * b + 128) >>> 8) + (1 << (DW - 1)));
    if (!de) return '0;
    case (md)
      2'd0:    return p;
      2'd1:    return {y, {(2*DW){1'b0}}};
      2'd2:    return {y, cb, cr};
      default: return (y >= th) ? '1 : '0;
    endcase
  endfunction

  task automatic model_reset();
    out_t z;
    z = '{px: '0, de: 1'b0, hs: 1'b0, vs: 1'b0};
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
    m_mode    = 2'd1;
    m_thr     = '0;
    m_vs_prev = 1'b0;
  endtask

  // One clock: update the model at the edge, compare every output at the next negedge.
  task automatic step();
    out_t e_in, e_out;
    @(posedge clk);
    e_in = '{px: ref_pix(din, de_in, m_mode, m_thr), de: de_in, hs: hs_in, vs: vs_in};
    exp_q.push_back(e_in);
    if (vs_in && !m_vs_prev) begin
      m_mode = mode;
      m_thr  = thresh;
    end
    m_vs_prev = vs_in;
    e_out = exp_q.pop_front();
    @(negedge clk);
    check_eq("dout", 64'(dout), 64'(e_out.px));
    check_eq("de_out", 64'(de_out), 64'(e_out.de));
    check_eq("hs_out", 64'(hs_out), 64'(e_out.hs));
    check_eq("vs_out", 64'(vs_out), 64'(e_out.vs));
    check_eq("mode_act", 64'(mode_act), 64'(m_mode));
  endtask

  task automatic drive(input logic [W-1:0] px, input logic de, input logic hs, input logic vs);
    din   = px;
    de_in = de;
    hs_in = hs;
    vs_in = vs;
    step();
  endtask

  task automatic vs_pulse(input logic [1:0] md, input logic [DW-1:0] th);
    mode   = md;
    thresh = th;
    drive('0, 1'b0, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b0, 1'b0);
  endtask

  // Single pixel followed by idle cycles; checks the converted value against a constant.
  task automatic px_const(input string tag, input logic [W-1:0] px, input logic [W-1:0] exp);
    drive(px, 1'b1, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0);
    check_eq(tag, 64'(dout), 64'(exp));
  endtask

  initial begin
    rst_n  = 1'b0;
    din    = '0;
    de_in  = 1'b0;
    hs_in  = 1'b0;
    vs_in  = 1'b0;
    mode   = 2'd0;
    thresh = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_dout", 64'(dout), 64'h0);
    check_eq("rst_mode_act", 64'(mode_act), 64'd1);
    rst_n = 1'b1;

    // Gray is the default after reset.
    px_const("gray_white", 24'hFFFFFF, 24'hFF0000);
    px_const("gray_red", 24'hFF0000, 24'h4D0000);

    vs_pulse(2'd2, 8'd0);
    px_const("ycc_red", 24'hFF0000, 24'h4D55FF);
    px_const("ycc_white", 24'hFFFFFF, 24'hFF8080);
    px_const("ycc_black", 24'h000000, 24'h008080);

    vs_pulse(2'd3, 8'd100);
    px_const("bin_red", 24'hFF0000, 24'h000000);
    px_const("bin_white", 24'hFFFFFF, 24'hFFFFFF);
    thresh = 8'd50;
    px_const("bin_midframe_thr", 24'hFF0000, 24'h000000);
    vs_pulse(2'd3, 8'd50);
    px_const("bin_new_thr", 24'hFF0000, 24'hFFFFFF);

    // Mode switch on the same cycle as the vsync edge with continuous data.
    vs_pulse(2'd1, 8'd0);
    repeat (4) drive(W'($urandom), 1'b1, 1'b0, 1'b0);
    mode = 2'd2;
    drive(W'($urandom), 1'b1, 1'b0, 1'b1);
    check_eq("mode_switch_act", 64'(mode_act), 64'd2);
    repeat (6) drive(W'($urandom), 1'b1, 1'b0, 1'b0);
    repeat (3) drive('0, 1'b0, 1'b0, 1'b0);

    // Random 16x4 frames with random modes, thresholds and data.
    for (int f = 0; f < 6; f++) begin
      mode   = 2'($urandom);
      thresh = DW'($urandom);
      drive(W'($urandom), 1'b0, 1'b0, 1'b1);
      drive(W'($urandom), 1'b0, 1'b0, 1'b1);
      for (int ln = 0; ln < 4; ln++) begin
        drive(W'($urandom), 1'b0, 1'b1, 1'b0);
        drive(W'($urandom), 1'b0, 1'b1, 1'b0);
        for (int px = 0; px < 16; px++) begin
          mode   = 2'($urandom);
          thresh = DW'($urandom);
          drive(W'($urandom), ($urandom_range(0, 9) < 8), 1'b0, 1'b0);
        end
      end
    end
    for (int i = 0; i < 200; i++) begin
      mode   = 2'($urandom);
      thresh = DW'($urandom);
      drive(W'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset in mid-stream with de held high.
    vs_pulse(2'd2, 8'd0);
    repeat (4) drive(24'hFFFFFF, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_dout", 64'(dout), 64'h0);
    check_eq("arst_de_out", 64'(de_out), 64'h0);
    check_eq("arst_mode_act", 64'(mode_act), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive('0, 1'b0, 1'b0, 1'b0);
    drive(24'hFFFFFF, 1'b1, 1'b0, 1'b0);
    check_eq("post_rst_de_c1", 64'(de_out), 64'h0);
    drive(24'hFFFFFF, 1'b1, 1'b0, 1'b0);
    check_eq("post_rst_de_c2", 64'(de_out), 64'h0);
    drive(24'hFFFFFF, 1'b1, 1'b0, 1'b0);
    check_eq("post_rst_de_c3", 64'(de_out), 64'h1);
    check_eq("post_rst_gray", 64'(dout), 64'hFF0000);
    repeat (3) drive('0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
